// File: rtl/fft_frame_ctrl_if.sv
// Complex bin stream from the FFT core into the frame controller.
// master = FFT core (drives bins), slave = frame controller (drives ready).
interface fft_frame_ctrl_if;
  logic               fft_in_valid;
  logic               fft_in_ready;
  logic               fft_in_last;
  logic signed [15:0] fft_in_re;
  logic signed [15:0] fft_in_im;

  modport master (output fft_in_valid, fft_in_last, fft_in_re, fft_in_im,
                  input  fft_in_ready);
  modport slave  (input  fft_in_valid, fft_in_last, fft_in_re, fft_in_im,
                  output fft_in_ready);
endinterface

// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: kicks one FFT frame per refresh interval, accepts the
// bin stream, converts bins to 8-bit |re|+|im| magnitudes and writes the first
// BUF_DEPTH bins into the spectrum buffer. Malformed frames raise frame_err.
module fft_frame_ctrl #(
  parameter int          FFT_LEN   = 2048,
  parameter int          BUF_DEPTH = 1024,
  parameter int          MAG_SHIFT = 6,
  parameter logic [19:0] GAP_CYC   = 20'd500000,
  localparam int         CNT_W     = $clog2(FFT_LEN),
  localparam int         ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              freeze,
  output logic              fft_start,
  fft_frame_ctrl_if.slave   bin_if,
  output logic              fft_buf_wr,
  output logic [ADDR_W-1:0] fft_buf_addr,
  output logic [7:0]        fft_buf_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int STAGES = 2;

  typedef enum logic [2:0] {IDLE, START, RECV, DRAIN, GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bin_cnt;
  logic               drain_cnt;
  logic [19:0]        gap_cnt;
  logic               err_flag;
  logic               start_nxt, ready_nxt, done_nxt, err_nxt;

  // handshake decode; ready is only ever high in RECV
  logic accept, is_end, fin, bad, in_buf;
  assign accept = bin_if.fft_in_valid & bin_if.fft_in_ready;
  assign is_end = (bin_cnt == CNT_W'(FFT_LEN - 1));
  assign fin    = accept & (bin_if.fft_in_last | is_end);
  assign bad    = accept & (bin_if.fft_in_last ^ is_end);
  assign in_buf = accept & (int'(bin_cnt) < BUF_DEPTH);

  // state register
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and next values of the registered control outputs
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = bad;
    unique case (state)
      IDLE:  if (enable && !freeze) state_nxt = START;
      START: begin
        state_nxt = RECV;
        start_nxt = 1'b1;
      end
      RECV:  if (fin) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) begin
        state_nxt = GAP;
        done_nxt  = !err_flag;
      end
      GAP:   if (!enable || gap_cnt == GAP_CYC - 20'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == RECV);
  end

  // registered control outputs
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_start           <= 1'b0;
      bin_if.fft_in_ready <= 1'b0;
      frame_done          <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      fft_start           <= start_nxt;
      bin_if.fft_in_ready <= ready_nxt;
      frame_done          <= done_nxt;
      frame_err           <= err_nxt;
    end
  end

  // bin, drain and gap counters plus the per-frame error latch
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      drain_cnt <= 1'b0;
      gap_cnt   <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (state == START)  bin_cnt <= '0;
      else if (accept)     bin_cnt <= bin_cnt + 1'b1;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      gap_cnt   <= (state == GAP) ? gap_cnt + 20'd1 : 20'd0;
      if (state == START)  err_flag <= 1'b0;
      else if (bad)        err_flag <= 1'b1;
    end
  end

  // |x| in 17 bits so that -32768 maps to 32768 without wrapping
  logic [16:0] re_abs, im_abs, mag_s1, sc;
  logic [ADDR_W-1:0] idx_s1;
  logic [STAGES:1]   vld_pipe;
  assign re_abs = bin_if.fft_in_re[15] ? 17'd0 - {1'b1, bin_if.fft_in_re}
                                       : {1'b0, bin_if.fft_in_re};
  assign im_abs = bin_if.fft_in_im[15] ? 17'd0 - {1'b1, bin_if.fft_in_im}
                                       : {1'b0, bin_if.fft_in_im};
  assign sc     = mag_s1 >> MAG_SHIFT;

  // two-stage magnitude pipeline; only bins below BUF_DEPTH carry a valid
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      mag_s1       <= '0;
      idx_s1       <= '0;
      fft_buf_addr <= '0;
      fft_buf_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_buf};
      if (in_buf) begin
        mag_s1 <= re_abs + im_abs;
        idx_s1 <= bin_cnt[ADDR_W-1:0];
      end
      if (vld_pipe[1]) begin
        fft_buf_addr <= idx_s1;
        fft_buf_data <= (sc > 17'd255) ? 8'hFF : sc[7:0];
      end
    end
  end

  assign fft_buf_wr = vld_pipe[STAGES];

endmodule
